// File: rtl/df_prof_pkg.sv
// Shared types and helpers for the dataflow channel profiler.
// Holds the run-state encoding, readout field codes, flag bit positions and a saturating increment.
package df_prof_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } prof_state_e;

  localparam logic [2:0] FLD_OCC      = 3'd0;
  localparam logic [2:0] FLD_WM       = 3'd1;
  localparam logic [2:0] FLD_RD_STALL = 3'd2;
  localparam logic [2:0] FLD_WR_STALL = 3'd3;
  localparam logic [2:0] FLD_FLAGS    = 3'd4;
  localparam logic [2:0] FLD_RUN      = 3'd5;

  localparam int FLAG_W     = 4;
  localparam int FLAG_OVF   = 0;
  localparam int FLAG_UDF   = 1;
  localparam int FLAG_SAT   = 2;
  localparam int FLAG_PROTO = 3;

  // Counters up to 64 bits share this; callers widen in and truncate out.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/df_chan_stats.sv
// Statistics for one monitored FIFO channel: occupancy, high-watermark,
// read/write stall counters and sticky error flags.
module df_chan_stats
  import df_prof_pkg::*;
#(
  parameter int DEPTH_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               run,
  input  logic               wr,
  input  logic               rd,
  input  logic               wr_block,
  input  logic               rd_block,
  output logic [DEPTH_W-1:0] occ,
  output logic [DEPTH_W-1:0] watermark,
  output logic [CNT_W-1:0]   rd_stall,
  output logic [CNT_W-1:0]   wr_stall,
  output logic [FLAG_W-1:0]  flags
);

  localparam logic [DEPTH_W-1:0] OCC_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  logic [DEPTH_W-1:0] occ_q, occ_d;
  logic [DEPTH_W-1:0] wm_q, wm_d;
  logic [CNT_W-1:0]   rs_q, rs_d;
  logic [CNT_W-1:0]   ws_q, ws_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;

  always_comb begin
    occ_d   = occ_q;
    wm_d    = wm_q;
    rs_d    = rs_q;
    ws_d    = ws_q;
    flags_d = flags_q;
    if (clr) begin
      occ_d   = '0;
      wm_d    = '0;
      rs_d    = '0;
      ws_d    = '0;
      flags_d = '0;
    end else if (run) begin
      if (wr && !rd) begin
        if (occ_q == OCC_MAX) flags_d[FLAG_OVF] = 1'b1;
        else                  occ_d = occ_q + 1'b1;
      end else if (rd && !wr) begin
        if (occ_q == '0) flags_d[FLAG_UDF] = 1'b1;
        else             occ_d = occ_q - 1'b1;
      end
      // Compare against the next occupancy so the watermark tracks in the same cycle.
      if (occ_d > wm_q) wm_d = occ_d;
      if (rd_block) begin
        rs_d = CNT_W'(sat_inc(64'(rs_q), CNT_W));
        if (rs_d == CNT_MAX) flags_d[FLAG_SAT] = 1'b1;
      end
      if (wr_block) begin
        ws_d = CNT_W'(sat_inc(64'(ws_q), CNT_W));
        if (ws_d == CNT_MAX) flags_d[FLAG_SAT] = 1'b1;
      end
      if (rd_block && wr_block) flags_d[FLAG_PROTO] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q   <= '0;
      wm_q    <= '0;
      rs_q    <= '0;
      ws_q    <= '0;
      flags_q <= '0;
    end else begin
      occ_q   <= occ_d;
      wm_q    <= wm_d;
      rs_q    <= rs_d;
      ws_q    <= ws_d;
      flags_q <= flags_d;
    end
  end

  assign occ       = occ_q;
  assign watermark = wm_q;
  assign rd_stall  = rs_q;
  assign wr_stall  = ws_q;
  assign flags     = flags_q;

endmodule

// File: rtl/df_channel_profiler.sv
// Dataflow region profiler: run FSM, deadlock detector, run-cycle counter and a
// two-stage readout pipeline over per-channel statistics.
module df_channel_profiler
  import df_prof_pkg::*;
#(
  parameter int NUM_CHAN = 7,
  parameter int DEPTH_W  = 8,
  parameter int CNT_W    = 32,
  parameter int DL_CYC   = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                finish,
  input  logic                clear,
  input  logic [NUM_CHAN-1:0] wr_en,
  input  logic [NUM_CHAN-1:0] rd_en,
  input  logic [NUM_CHAN-1:0] wr_block,
  input  logic [NUM_CHAN-1:0] rd_block,
  input  logic                rq_valid,
  input  logic [4:0]          rq_chan,
  input  logic [2:0]          rq_field,
  output logic                rs_valid,
  output logic [CNT_W-1:0]    rs_data,
  output logic [1:0]          state,
  output logic                deadlock,
  output logic [CNT_W-1:0]    run_cycles
);

  localparam int              DL_W    = $clog2(DL_CYC);
  localparam logic [DL_W-1:0] DL_LAST = DL_W'(DL_CYC - 1);

  prof_state_e      state_q, state_d;
  logic             deadlock_q, deadlock_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [DL_W-1:0]  dl_cnt_q, dl_cnt_d;
  logic             running, no_progress;

  logic [DEPTH_W-1:0] occ_a   [NUM_CHAN];
  logic [DEPTH_W-1:0] wm_a    [NUM_CHAN];
  logic [CNT_W-1:0]   rs_a    [NUM_CHAN];
  logic [CNT_W-1:0]   ws_a    [NUM_CHAN];
  logic [FLAG_W-1:0]  flags_a [NUM_CHAN];

  assign running     = (state_q == ST_RUN);
  assign no_progress = running && ((wr_en | rd_en) == '0) && ((wr_block | rd_block) != '0);

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    df_chan_stats #(
      .DEPTH_W (DEPTH_W),
      .CNT_W   (CNT_W)
    ) u_stats (
      .clock     (clock),
      .reset     (reset),
      .clr       (clear),
      .run       (running),
      .wr        (wr_en[g]),
      .rd        (rd_en[g]),
      .wr_block  (wr_block[g]),
      .rd_block  (rd_block[g]),
      .occ       (occ_a[g]),
      .watermark (wm_a[g]),
      .rd_stall  (rs_a[g]),
      .wr_stall  (ws_a[g]),
      .flags     (flags_a[g])
    );
  end

  // Priority: clear, then finish, then deadlock, then start.
  always_comb begin
    state_d    = state_q;
    deadlock_d = deadlock_q;
    run_d      = run_q;
    dl_cnt_d   = dl_cnt_q;
    if (clear) begin
      state_d    = ST_IDLE;
      deadlock_d = 1'b0;
      run_d      = '0;
      dl_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dl_cnt_d = '0;
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          run_d    = CNT_W'(sat_inc(64'(run_q), CNT_W));
          dl_cnt_d = no_progress ? dl_cnt_q + 1'b1 : '0;
          if (finish) begin
            state_d  = ST_FROZEN;
            dl_cnt_d = '0;
          end else if (no_progress && dl_cnt_q == DL_LAST) begin
            state_d    = ST_FROZEN;
            deadlock_d = 1'b1;
            dl_cnt_d   = '0;
          end
        end
        ST_FROZEN: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      deadlock_q <= 1'b0;
      run_q      <= '0;
      dl_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      deadlock_q <= deadlock_d;
      run_q      <= run_d;
      dl_cnt_q   <= dl_cnt_d;
    end
  end

  logic             sel_valid_q, sel_valid_d;
  logic [4:0]       sel_chan_q, sel_chan_d;
  logic [2:0]       sel_field_q, sel_field_d;
  logic             rs_valid_q, rs_valid_d;
  logic [CNT_W-1:0] rs_data_q, rs_data_d;
  logic [CNT_W-1:0] rd_val;

  // Out-of-range channels and unknown fields fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (sel_chan_q == 5'(i)) begin
        case (sel_field_q)
          FLD_OCC:      rd_val = CNT_W'(occ_a[i]);
          FLD_WM:       rd_val = CNT_W'(wm_a[i]);
          FLD_RD_STALL: rd_val = rs_a[i];
          FLD_WR_STALL: rd_val = ws_a[i];
          FLD_FLAGS:    rd_val = CNT_W'(flags_a[i]);
          FLD_RUN:      rd_val = run_q;
          default:      rd_val = '0;
        endcase
      end
    end
  end

  always_comb begin
    sel_valid_d = rq_valid;
    sel_chan_d  = rq_chan;
    sel_field_d = rq_field;
    rs_valid_d  = sel_valid_q;
    rs_data_d   = sel_valid_q ? rd_val : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_valid_q <= 1'b0;
      sel_chan_q  <= '0;
      sel_field_q <= '0;
      rs_valid_q  <= 1'b0;
      rs_data_q   <= '0;
    end else begin
      sel_valid_q <= sel_valid_d;
      sel_chan_q  <= sel_chan_d;
      sel_field_q <= sel_field_d;
      rs_valid_q  <= rs_valid_d;
      rs_data_q   <= rs_data_d;
    end
  end

  assign state      = state_q;
  assign deadlock   = deadlock_q;
  assign run_cycles = run_q;
  assign rs_valid   = rs_valid_q;
  assign rs_data    = rs_data_q;

endmodule

// File: tb/tb_df_channel_profiler.sv
// Randomised and directed bench for df_channel_profiler against a behavioural model;
// readout responses are queued when requested and retired by an independent monitor.
module tb_df_channel_profiler;

  localparam int     NC      = 7;
  localparam int     DW      = 3;
  localparam int     CW      = 6;
  localparam int     DLC     = 16;
  localparam longint OCC_MAX = (64'd1 << DW) - 1;
  localparam longint CNT_MAX = (64'd1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          finish = 1'b0;
  logic          clear = 1'b0;
  logic [NC-1:0] wr_en = '0;
  logic [NC-1:0] rd_en = '0;
  logic [NC-1:0] wr_block = '0;
  logic [NC-1:0] rd_block = '0;
  logic          rq_valid = 1'b0;
  logic [4:0]    rq_chan = '0;
  logic [2:0]    rq_field = '0;
  logic          rs_valid;
  logic [CW-1:0] rs_data;
  logic [1:0]    state;
  logic          deadlock;
  logic [CW-1:0] run_cycles;

  df_channel_profiler #(
    .NUM_CHAN (NC),
    .DEPTH_W  (DW),
    .CNT_W    (CW),
    .DL_CYC   (DLC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .finish     (finish),
    .clear      (clear),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wr_block   (wr_block),
    .rd_block   (rd_block),
    .rq_valid   (rq_valid),
    .rq_chan    (rq_chan),
    .rq_field   (rq_field),
    .rs_valid   (rs_valid),
    .rs_data    (rs_data),
    .state      (state),
    .deadlock   (deadlock),
    .run_cycles (run_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    int     due;
    longint data;
  } exp_t;

  exp_t   sb[$];
  int     edge_n = 0;
  int     n_checks = 0;
  int     n_pass = 0;

  // Behavioural model: 0 idle, 1 running, 2 frozen.
  int     m_state = 0;
  bit     m_dl = 1'b0;
  longint m_run = 0;
  int     m_stuck = 0;
  longint m_occ[NC];
  longint m_wm[NC];
  longint m_rs[NC];
  longint m_ws[NC];
  longint m_flags[NC];

  task automatic zero_model();
    m_run = 0;
    m_stuck = 0;
    m_dl = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_occ[c] = 0; m_wm[c] = 0; m_rs[c] = 0; m_ws[c] = 0; m_flags[c] = 0;
    end
  endtask

  function automatic longint model_read(int c, int f);
    if (c >= NC) return 0;
    case (f)
      0: return m_occ[c];
      1: return m_wm[c];
      2: return m_rs[c];
      3: return m_ws[c];
      4: return m_flags[c];
      5: return m_run;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit fin, input bit clr,
                            input bit [NC-1:0] wr, input bit [NC-1:0] rd,
                            input bit [NC-1:0] wb, input bit [NC-1:0] rb,
                            input bit rqv, input int rqc, input int rqf);
    bit stuck;
    if (rst) begin
      zero_model();
      m_state = 0;
      while (sb.size() > 0 && sb[$].due >= edge_n + 1) void'(sb.pop_back());
      return;
    end
    if (clr) begin
      zero_model();
      m_state = 0;
    end else if (m_state == 1) begin
      for (int c = 0; c < NC; c++) begin
        if (wr[c] && !rd[c]) begin
          if (m_occ[c] == OCC_MAX) m_flags[c] |= 1;
          else m_occ[c] += 1;
        end else if (rd[c] && !wr[c]) begin
          if (m_occ[c] == 0) m_flags[c] |= 2;
          else m_occ[c] -= 1;
        end
        if (m_occ[c] > m_wm[c]) m_wm[c] = m_occ[c];
        if (rb[c]) begin
          if (m_rs[c] < CNT_MAX) m_rs[c] += 1;
          if (m_rs[c] == CNT_MAX) m_flags[c] |= 4;
        end
        if (wb[c]) begin
          if (m_ws[c] < CNT_MAX) m_ws[c] += 1;
          if (m_ws[c] == CNT_MAX) m_flags[c] |= 4;
        end
        if (rb[c] && wb[c]) m_flags[c] |= 8;
      end
      if (m_run < CNT_MAX) m_run += 1;
      stuck = ((wr | rd) == '0) && ((wb | rb) != '0);
      if (fin) m_state = 2;
      else if (stuck && m_stuck == DLC - 1) begin
        m_state = 2;
        m_dl = 1'b1;
      end
      m_stuck = stuck ? m_stuck + 1 : 0;
    end else if (m_state == 0 && st) begin
      m_state = 1;
      m_stuck = 0;
    end
    if (rqv) sb.push_back('{due: edge_n + 2, data: model_read(rqc, rqf)});
  endtask

  task automatic applyStimulus(input bit rst, input bit st, input bit fin, input bit clr,
                               input bit [NC-1:0] wr, input bit [NC-1:0] rd,
                               input bit [NC-1:0] wb, input bit [NC-1:0] rb,
                               input bit rqv, input int rqc, input int rqf);
    @(negedge clock);
    reset = rst; start = st; finish = fin; clear = clr;
    wr_en = wr; rd_en = rd; wr_block = wb; rd_block = rb;
    rq_valid = rqv; rq_chan = 5'(rqc); rq_field = 3'(rqf);
    model_step(rst, st, fin, clr, wr, rd, wb, rb, rqv, rqc, rqf);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, '0, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic ctl(input bit rst, input bit st, input bit fin, input bit clr);
    applyStimulus(rst, st, fin, clr, '0, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic xfer(input bit [NC-1:0] wr, input bit [NC-1:0] rd,
                      input bit [NC-1:0] wb, input bit [NC-1:0] rb);
    applyStimulus(0, 0, 0, 0, wr, rd, wb, rb, 0, 0, 0);
  endtask

  task automatic req(input int c, input int f);
    applyStimulus(0, 0, 0, 0, '0, '0, '0, '0, 1, c, f);
  endtask

  task automatic read_all();
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < 6; f++) req(c, f);
    req(9, 3);
    req(0, 6);
    idle(3);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  task automatic checkOutput();
    exp_t e;
    check("state", 64'(state), 64'(m_state));
    check("deadlock", 64'(deadlock), 64'(m_dl));
    check("run_cycles", 64'(run_cycles), 64'(m_run));
    if (sb.size() > 0 && sb[0].due == edge_n) begin
      e = sb.pop_front();
      check("rs_valid", 64'(rs_valid), 64'd1);
      check("rs_data", 64'(rs_data), 64'(e.data));
    end else if (rs_valid !== 1'b0) begin
      check("rs_spurious", 64'(rs_valid), 64'd0);
    end
  endtask

  always @(posedge clock) begin
    #1;
    edge_n++;
    checkOutput();
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    zero_model();
    ctl(1, 0, 0, 0);
    ctl(1, 0, 0, 0);
    idle(2);
    read_all();

    // Basic occupancy / watermark run on channel 0.
    ctl(0, 1, 0, 0);
    repeat (5) xfer(7'b0000001, '0, '0, '0);
    repeat (2) xfer('0, 7'b0000001, '0, '0);
    xfer(7'b0000001, 7'b0000001, '0, '0);
    ctl(0, 0, 1, 0);
    read_all();
    ctl(0, 0, 0, 1);

    // Underflow on ch1, overflow on ch2.
    ctl(0, 1, 0, 0);
    xfer('0, 7'b0000010, '0, '0);
    repeat (9) xfer(7'b0000100, '0, '0, '0);
    ctl(0, 0, 1, 0);
    read_all();
    ctl(0, 0, 0, 1);

    // Deadlock with an interrupting transfer.
    ctl(0, 1, 0, 0);
    repeat (9) xfer('0, '0, '0, 7'b0001000);
    xfer(7'b0000001, '0, '0, 7'b0001000);
    repeat (30) xfer('0, '0, '0, 7'b0001000);
    read_all();
    ctl(0, 0, 0, 1);

    // finish coinciding with the deadlock-declaring cycle wins.
    ctl(0, 1, 0, 0);
    repeat (15) xfer('0, '0, '0, 7'b0001000);
    applyStimulus(0, 0, 1, 0, '0, '0, '0, 7'b0001000, 0, 0, 0);
    idle(2);
    ctl(0, 0, 0, 1);

    // Write stalls then readout, including an out-of-range channel.
    ctl(0, 1, 0, 0);
    repeat (20) xfer('0, '0, 7'b0010000, '0);
    ctl(0, 0, 1, 0);
    req(4, 3);
    req(9, 3);
    req(9, 0);
    idle(3);
    ctl(0, 0, 0, 1);

    // Saturation of stall and run counters, plus a protocol error.
    ctl(0, 1, 0, 0);
    xfer('0, '0, 7'b0100000, 7'b0100000);
    repeat (70) xfer('0, 7'b0000001, '0, 7'b0000001);
    ctl(0, 0, 1, 0);
    read_all();
    ctl(0, 0, 0, 1);
    read_all();

    // Reset mid-run with readouts in flight.
    ctl(0, 1, 0, 0);
    repeat (3) xfer(7'b0000001, '0, '0, '0);
    req(0, 0);
    applyStimulus(1, 0, 0, 0, '0, '0, '0, '0, 1, 0, 5);
    idle(1);
    read_all();

    // Randomised traffic with occasional control events.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 399) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 149) == 0,
                    $urandom_range(0, 299) == 0,
                    NC'($urandom & $urandom),
                    NC'($urandom & $urandom),
                    NC'($urandom & $urandom & $urandom),
                    NC'($urandom & $urandom & $urandom),
                    $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 7)));
    end
    idle(4);
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
